// File: rtl/vga_timing_pkg.sv
// Shared 800x600@72 Hz timing constants, monitor error-bit map, state encoding and CRC helper.
package vga_timing_pkg;

  localparam int VGA_H_TOTAL      = 1040;
  localparam int VGA_H_ACTIVE     = 800;
  localparam int VGA_H_SYNC_START = 856;
  localparam int VGA_H_SYNC_W     = 120;
  localparam int VGA_V_TOTAL      = 666;
  localparam int VGA_V_ACTIVE     = 600;
  localparam int VGA_V_SYNC_START = 637;
  localparam int VGA_V_SYNC_W     = 6;
  localparam int VGA_LOCK_FRAMES  = 2;

  localparam int ERR_HPER   = 0;
  localparam int ERR_HWID   = 1;
  localparam int ERR_VPER   = 2;
  localparam int ERR_VWID   = 3;
  localparam int ERR_VALIGN = 4;
  localparam int ERR_TMO    = 5;
  localparam int ERR_W      = 6;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } mon_state_e;

  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'h1021;

  // CRC-16-CCITT, MSB first, one byte per call.
  function automatic logic [15:0] crc16_ccitt_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    return c;
  endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Sync sampler: registers one sync line, flags rise/fall of the sample being captured and
// counts enabled samples while the pulse is high.
module vga_sync_edge #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sync_i,
  input  logic         cnt_en_i,
  output logic         rise_o,
  output logic         fall_o,
  output logic [W-1:0] wid_o
);

  logic         s_q;
  logic [W-1:0] wid_q, wid_d;

  // Edges are taken between the incoming sample and the captured one, so every registered
  // result lands on the same edge that loads the sample into stage 1.
  assign rise_o = sync_i & ~s_q;
  assign fall_o = ~sync_i & s_q;
  assign wid_o  = wid_q;

  always_comb begin
    wid_d = wid_q;
    if (rise_o)
      wid_d = W'(cnt_en_i);
    else if (sync_i && cnt_en_i && wid_q != '1)
      wid_d = wid_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q   <= 1'b0;
      wid_q <= '0;
    end else begin
      s_q   <= sync_i;
      wid_q <= wid_d;
    end
  end

endmodule

// File: rtl/vga_timing_monitor.sv
// Receive-side VGA timing monitor: recovers X/Y, checks line/frame timing, tracks lock.
// Optional frame CRC on active pixels when VGA_TIMING_MONITOR_CRC_EN is defined.
module vga_timing_monitor
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL      = VGA_H_TOTAL,
  parameter int H_ACTIVE     = VGA_H_ACTIVE,
  parameter int H_SYNC_START = VGA_H_SYNC_START,
  parameter int H_SYNC_W     = VGA_H_SYNC_W,
  parameter int V_TOTAL      = VGA_V_TOTAL,
  parameter int V_ACTIVE     = VGA_V_ACTIVE,
  parameter int V_SYNC_START = VGA_V_SYNC_START,
  parameter int V_SYNC_W     = VGA_V_SYNC_W,
  parameter int LOCK_FRAMES  = VGA_LOCK_FRAMES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hsync_i,
  input  logic              vsync_i,
  input  logic [5:0]        pix_i,
  input  logic              err_clr,
`ifdef VGA_TIMING_MONITOR_CRC_EN
  output logic [15:0]       frame_crc,
  output logic              crc_valid,
`endif
  output logic              locked,
  output logic [10:0]       rec_x,
  output logic [9:0]        rec_y,
  output logic              in_active,
  output logic [5:0]        pix_o,
  output logic [ERR_W-1:0]  err_flags,
  output logic              lock_lost,
  output logic [15:0]       frame_cnt
);

  localparam int XW = 11;
  localparam int YW = 10;
  localparam int PW = 12;  // must hold 2*H_TOTAL
  localparam int WW = 11;

  localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] X_SYNC   = XW'(H_SYNC_START);
  localparam logic [XW-1:0] X_ACT    = XW'(H_ACTIVE);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] Y_SYNC   = YW'(V_SYNC_START);
  localparam logic [YW-1:0] Y_ACT    = YW'(V_ACTIVE);
  localparam logic [YW-1:0] V_LINES  = YW'(V_TOTAL);
  localparam logic [PW-1:0] P_LINE   = PW'(H_TOTAL);
  localparam logic [PW-1:0] P_SAT    = PW'(2 * H_TOTAL);
  localparam logic [WW-1:0] HW_NOM   = WW'(H_SYNC_W);
  localparam logic [WW-1:0] VW_NOM   = WW'(V_SYNC_W);
  localparam logic [3:0]    GOOD_LCK = 4'(LOCK_FRAMES);

  logic          hr, hf, vr, vf;
  logic [WW-1:0] h_wid, v_wid;

  vga_sync_edge #(.W(WW)) u_hs (
    .clk(clk), .rst(rst), .sync_i(hsync_i), .cnt_en_i(1'b1),
    .rise_o(hr), .fall_o(hf), .wid_o(h_wid)
  );

  // Vsync width is measured in lines, so only hsync rises are counted.
  vga_sync_edge #(.W(WW)) u_vs (
    .clk(clk), .rst(rst), .sync_i(vsync_i), .cnt_en_i(hr),
    .rise_o(vr), .fall_o(vf), .wid_o(v_wid)
  );

  logic [XW-1:0]    x_q, x_d, x_nom;
  logic [YW-1:0]    y_q, y_d;
  logic [PW-1:0]    h_per_q, h_per_d;
  logic [YW-1:0]    v_lines_q, v_lines_d;
  logic             h_seen_q, h_seen_d, v_seen_q, v_seen_d;
  logic             frame_bad_q, frame_bad_d;
  logic [ERR_W-1:0] err, err_flags_q, err_flags_d;
  logic             err_any, timeout;
  logic [5:0]       pix_q;

  mon_state_e       state_q;
  logic [3:0]       good_q;
  logic [15:0]      frame_cnt_q;
  logic             lock_lost_q;

  always_comb begin
    x_nom     = (x_q == X_LAST) ? '0 : x_q + 1'b1;
    x_d       = hr ? X_SYNC : x_nom;
    y_d       = y_q;
    if (vr)
      y_d = Y_SYNC;
    else if (!hr && x_q == X_LAST)
      y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;

    h_per_d   = hr ? PW'(1) : ((h_per_q == P_SAT) ? h_per_q : h_per_q + 1'b1);
    // Timeout fires once on reaching saturation; h_seen gating keeps it from repeating.
    timeout   = !hr && h_seen_q && (h_per_q == P_SAT - 1'b1);

    v_lines_d = v_lines_q;
    if (vr)
      v_lines_d = YW'(hr);
    else if (hr && v_lines_q != '1)
      v_lines_d = v_lines_q + 1'b1;

    err             = '0;
    err[ERR_HPER]   = hr & h_seen_q & (h_per_q != P_LINE);
    err[ERR_HWID]   = hf & h_seen_q & (h_wid != HW_NOM);
    err[ERR_VPER]   = vr & v_seen_q & (v_lines_q != V_LINES);
    err[ERR_VWID]   = vf & (v_wid != VW_NOM);
    err[ERR_VALIGN] = vr & h_seen_q & (x_d != '0);
    err[ERR_TMO]    = timeout;
    err_any         = |err;

    h_seen_d    = timeout ? 1'b0 : (h_seen_q | hr);
    v_seen_d    = timeout ? 1'b0 : (v_seen_q | vr);
    err_flags_d = (err_clr ? '0 : err_flags_q) | err;
    frame_bad_d = vr ? 1'b0 : (frame_bad_q | err_any);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q         <= '0;
      y_q         <= '0;
      h_per_q     <= '0;
      v_lines_q   <= '0;
      h_seen_q    <= 1'b0;
      v_seen_q    <= 1'b0;
      frame_bad_q <= 1'b0;
      err_flags_q <= '0;
      pix_q       <= '0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      h_per_q     <= h_per_d;
      v_lines_q   <= v_lines_d;
      h_seen_q    <= h_seen_d;
      v_seen_q    <= v_seen_d;
      frame_bad_q <= frame_bad_d;
      err_flags_q <= err_flags_d;
      pix_q       <= pix_i;
    end
  end

  // An error always wins over a vrise arriving in the same sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_UNLOCKED;
      good_q      <= '0;
      frame_cnt_q <= '0;
      lock_lost_q <= 1'b0;
    end else begin
      lock_lost_q <= 1'b0;
      case (state_q)
        ST_UNLOCKED: begin
          if (!err_any && vr) begin
            state_q <= ST_ACQUIRE;
            good_q  <= '0;
          end
        end
        ST_ACQUIRE: begin
          if (err_any) begin
            state_q <= ST_UNLOCKED;
          end else if (vr && !frame_bad_q && v_seen_q) begin
            good_q      <= good_q + 1'b1;
            frame_cnt_q <= frame_cnt_q + 1'b1;
            if (good_q + 1'b1 == GOOD_LCK) state_q <= ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (err_any) begin
            state_q     <= ST_UNLOCKED;
            lock_lost_q <= 1'b1;
          end else if (vr && !frame_bad_q) begin
            frame_cnt_q <= frame_cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_UNLOCKED;
      endcase
    end
  end

  assign locked    = (state_q == ST_LOCKED);
  assign rec_x     = x_q;
  assign rec_y     = y_q;
  assign in_active = locked & (x_q < X_ACT) & (y_q < Y_ACT);
  assign pix_o     = pix_q;
  assign err_flags = err_flags_q;
  assign lock_lost = lock_lost_q;
  assign frame_cnt = frame_cnt_q;

`ifdef VGA_TIMING_MONITOR_CRC_EN
  logic [15:0] crc_run_q, crc_cur, frame_crc_q;
  logic        crc_valid_q;

  // The stage-1 sample is folded in on the edge that captures the next one, so a vrise
  // closes the frame including the last sample before it.
  assign crc_cur = in_active ? crc16_ccitt_byte(crc_run_q, {2'b00, pix_q}) : crc_run_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_run_q   <= CRC_INIT;
      frame_crc_q <= '0;
      crc_valid_q <= 1'b0;
    end else begin
      crc_valid_q <= vr & locked;
      if (vr) begin
        frame_crc_q <= crc_cur;
        crc_run_q   <= CRC_INIT;
      end else begin
        crc_run_q   <= crc_cur;
      end
    end
  end

  assign frame_crc = frame_crc_q;
  assign crc_valid = crc_valid_q;
`endif

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor on a scaled-down raster (40x20 clocks/lines).
// Covers CRC outputs when VGA_TIMING_MONITOR_CRC_EN is defined.
module tb_vga_timing_monitor;

  localparam int HT = 40, HA = 24, HSS = 28, HSW = 6;
  localparam int VT = 20, VA = 12, VSS = 15, VSW = 3;

  logic        clk = 1'b0;
  logic        rst, hsync_i, vsync_i, err_clr;
  logic [5:0]  pix_i;
  logic        locked, in_active, lock_lost;
  logic [10:0] rec_x;
  logic [9:0]  rec_y;
  logic [5:0]  pix_o, err_flags;
  logic [15:0] frame_cnt;
`ifdef VGA_TIMING_MONITOR_CRC_EN
  logic [15:0] frame_crc;
  logic        crc_valid;
`endif

  always #5 clk = ~clk;

  vga_timing_monitor #(
    .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_W(HSW),
    .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_W(VSW), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .hsync_i(hsync_i), .vsync_i(vsync_i), .pix_i(pix_i),
    .err_clr(err_clr),
`ifdef VGA_TIMING_MONITOR_CRC_EN
    .frame_crc(frame_crc), .crc_valid(crc_valid),
`endif
    .locked(locked), .rec_x(rec_x), .rec_y(rec_y), .in_active(in_active),
    .pix_o(pix_o), .err_flags(err_flags), .lock_lost(lock_lost), .frame_cnt(frame_cnt)
  );

  int ntests = 0, nfail = 0;
  int gx, gy, long_y, hs_w, vs_w, vs_x;
  bit hs_en;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive the sample at (gx,gy), clock it into stage 1, then advance the raster.
  task automatic tick();
    bit a, b;
    hsync_i = hs_en && gx >= HSS && gx < HSS + hs_w;
    a = (gy > VSS) || (gy == VSS && gx >= vs_x);
    b = (gy < VSS + vs_w) || (gy == VSS + vs_w && gx < vs_x);
    vsync_i = a && b;
    @(posedge clk); #1;
    gx++;
    if (gx == ((gy == long_y) ? HT + 1 : HT)) begin
      if (gy == long_y) long_y = -1;
      gx = 0;
      gy = (gy + 1) % VT;
    end
  endtask

  task automatic run_to(input int y, input int x);
    while (!(gx == x && gy == y)) tick();
  endtask

  task automatic next_vrise();
    run_to(VSS, 0);
    tick();
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  function automatic logic [15:0] crc_model(input int n, input logic [7:0] d);
    logic [15:0] c;
    bit fb;
    c = 16'hFFFF;
    for (int k = 0; k < n; k++)
      for (int i = 7; i >= 0; i--) begin
        fb = c[15] ^ d[i];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    return c;
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; hsync_i = 1'b0; vsync_i = 1'b0; err_clr = 1'b0; pix_i = 6'h0F;
    gx = 0; gy = 0; long_y = -1; hs_w = HSW; vs_w = VSW; vs_x = 0; hs_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_rec_x", rec_x, 0);
    chk("rst_rec_y", rec_y, 0);
    chk("rst_err", err_flags, 0);
    chk("rst_fcnt", frame_cnt, 0);
    chk("rst_lost", lock_lost, 0);
    chk("rst_active", in_active, 0);
    rst = 1'b0;

    // first hrise snaps X, pixel pass-through
    run_to(0, HSS); tick();
    chk("hrise_x", rec_x, HSS);
    run_to(0, 30); pix_i = 6'h2A; tick(); pix_i = 6'h0F;
    chk("pix_o", pix_o, 6'h2A);

    // acquisition: v1 -> ACQUIRE, v2 counts, v3 locks
    next_vrise();
    chk("vrise_y", rec_y, VSS);
    chk("vrise_x", rec_x, 0);
    chk("v1_locked", locked, 0);
    next_vrise();
    chk("v2_fcnt", frame_cnt, 1);
    chk("v2_locked", locked, 0);
    next_vrise();
    chk("v3_locked", locked, 1);
    chk("v3_fcnt", frame_cnt, 2);
    chk("v3_err", err_flags, 0);
`ifdef VGA_TIMING_MONITOR_CRC_EN
    chk("v3_crcv", crc_valid, 0);
`endif

    // active window edges
    run_to(1, 5); tick();
    chk("act_in", in_active, 1);
    chk("act_x", rec_x, 5);
    chk("act_y", rec_y, 1);
    run_to(1, HA); tick();
    chk("act_xedge", in_active, 0);
    run_to(VA - 1, HA - 1); tick();
    chk("act_corner", in_active, 1);
    run_to(VA, 0); tick();
    chk("act_yedge", in_active, 0);

    next_vrise();
    chk("v4_fcnt", frame_cnt, 3);
`ifdef VGA_TIMING_MONITOR_CRC_EN
    chk("v4_crcv", crc_valid, 1);
    chk("v4_crc", frame_crc, crc_model(HA * VA, 8'h0F));
    tick();
    chk("crcv_pulse", crc_valid, 0);
`endif
    next_vrise();
    chk("v5_fcnt", frame_cnt, 4);
`ifdef VGA_TIMING_MONITOR_CRC_EN
    chk("v5_crcv", crc_valid, 1);
    chk("v5_crc", frame_crc, crc_model(HA * VA, 8'h0F));
`endif

    // one line of HT+1 clocks while locked
    run_to(3, 0); long_y = 3;
    run_to(4, HSS);
    chk("hper_pre", err_flags, 0);
    tick();
    chk("hper_err", err_flags, 6'b000001);
    chk("hper_lost", lock_lost, 1);
    chk("hper_locked", locked, 0);
    tick();
    chk("lost_pulse", lock_lost, 0);
    clear_errs();
    chk("clr_err", err_flags, 0);
    next_vrise();
    chk("v6_locked", locked, 0);
    next_vrise();
    chk("v7_fcnt", frame_cnt, 5);
    next_vrise();
    chk("v8_locked", locked, 1);
    chk("v8_fcnt", frame_cnt, 6);

    // short hsync pulse
    run_to(2, 0); hs_w = HSW - 1;
    run_to(2, HSS + HSW - 1);
    chk("hwid_pre", err_flags, 0);
    tick();
    chk("hwid_err", err_flags, 6'b000010);
    chk("hwid_locked", locked, 0);
    run_to(3, 0); hs_w = HSW;
    clear_errs();

    // short vsync pulse
    vs_w = VSW - 1;
    run_to(VSS + VSW - 1, 0); tick();
    chk("vwid_err", err_flags, 6'b001000);
    run_to(19, 0); vs_w = VSW;
    clear_errs();
    next_vrise(); next_vrise(); next_vrise();
    chk("v12_locked", locked, 1);
    chk("v12_fcnt", frame_cnt, 8);

    // vsync rising one pixel late
    run_to(14, 0); vs_x = 1;
    run_to(VSS, 1); tick();
    chk("valign_err", err_flags, 6'b010000);
    chk("valign_lost", lock_lost, 1);
    chk("valign_fcnt", frame_cnt, 8);
    tick();
    chk("valign_locked", locked, 0);
    run_to(19, 0); vs_x = 0;
    clear_errs();
    next_vrise(); next_vrise(); next_vrise();
    chk("v16_locked", locked, 1);
    chk("v16_fcnt", frame_cnt, 10);

    // hsync missing for three lines
    run_to(1, 0); hs_en = 1'b0;
    run_to(2, HSS - 1);
    chk("tmo_pre", err_flags, 0);
    tick();
    chk("tmo_err", err_flags, 6'b100000);
    chk("tmo_locked", locked, 0);
    chk("tmo_lost", lock_lost, 1);
    run_to(4, 0); hs_en = 1'b1;
    clear_errs();
    next_vrise(); next_vrise(); next_vrise();
    chk("v19_locked", locked, 1);
    chk("v19_fcnt", frame_cnt, 12);
    chk("v19_err", err_flags, 0);

    // reset mid-frame, then full re-acquisition
    run_to(5, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mrst_locked", locked, 0);
    chk("mrst_fcnt", frame_cnt, 0);
    chk("mrst_rec_y", rec_y, 0);
    next_vrise();
    chk("v20_locked", locked, 0);
    next_vrise();
    chk("v21_fcnt", frame_cnt, 1);
    chk("v21_locked", locked, 0);
    next_vrise();
    chk("v22_locked", locked, 1);
    chk("v22_fcnt", frame_cnt, 2);
    chk("v22_err", err_flags, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
